// File: rtl/clock_hms_bcd.sv
// 24-hour BCD time-of-day counter with validated parallel load and minute/hour set pulses.
// Carry strobes are combinational so a downstream date or alarm stage can cascade off tick_1s.
module clock_hms_bcd #(
    parameter logic [7:0] INIT_HH = 8'h00,
    parameter logic [7:0] INIT_MM = 8'h00,
    parameter logic [7:0] INIT_SS = 8'h00
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       load,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic [7:0] ld_ss,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       min_rco,
    output logic       hour_rco,
    output logic       day_rco,
    output logic       ld_err
);

    logic [7:0] hh_p0, mm_p0, ss_p0;
    logic       ld_err_p0;
    logic       ld_ok, min_adv, hour_adv;

    function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [7:0] h, input logic [7:0] m,
                                    input logic [7:0] s);
        logic hr_ok;
        hr_ok = (h[7:4] <= 4'd1 && h[3:0] <= 4'd9) || (h[7:4] == 4'd2 && h[3:0] <= 4'd3);
        return hr_ok && (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9)
                     && (s[7:4] <= 4'd5) && (s[3:0] <= 4'd9);
    endfunction

    assign min_rco  = tick_1s & (ss_p0 == 8'h59);
    assign hour_rco = min_rco & (mm_p0 == 8'h59);
    assign day_rco  = hour_rco & (hh_p0 == 8'h23);

    // inc_min swallows the tick's minute carry, so no hour carry can follow from it
    always_comb begin
        ld_ok    = bcd_ok(ld_hh, ld_mm, ld_ss);
        min_adv  = inc_min | min_rco;
        hour_adv = inc_hour | (hour_rco & ~inc_min);
    end

    // stage p0: time registers
    always_ff @(posedge mclk) begin
        if (reset) begin
            hh_p0     <= INIT_HH;
            mm_p0     <= INIT_MM;
            ss_p0     <= INIT_SS;
            ld_err_p0 <= 1'b0;
        end else begin
            ld_err_p0 <= 1'b0;
            if (load) begin
                if (ld_ok) begin
                    hh_p0 <= ld_hh;
                    mm_p0 <= ld_mm;
                    ss_p0 <= ld_ss;
                end else begin
                    ld_err_p0 <= 1'b1;
                end
            end else begin
                if (tick_1s)
                    ss_p0 <= bcd_inc60(ss_p0);
                if (min_adv)
                    mm_p0 <= bcd_inc60(mm_p0);
                if (hour_adv)
                    hh_p0 <= bcd_inc24(hh_p0);
            end
        end
    end

    assign hh     = hh_p0;
    assign mm     = mm_p0;
    assign ss     = ss_p0;
    assign ld_err = ld_err_p0;

endmodule

// File: tb/tb_clock_hms_bcd.sv
// Directed bench for clock_hms_bcd: an integer time model feeds a scoreboard queue
// of expected registered outputs, and carry strobes are checked in the drive cycle.
module tb_clock_hms_bcd;

    logic       mclk = 1'b0;
    logic       reset, tick_1s, load, inc_min, inc_hour;
    logic [7:0] ld_hh, ld_mm, ld_ss;
    logic [7:0] hh, mm, ss;
    logic       min_rco, hour_rco, day_rco, ld_err;

    int tests = 0;
    int fails = 0;

    int m_h = 0, m_m = 0, m_s = 0;
    logic m_err = 1'b0;
    logic [24:0] sb[$];

    always #5 mclk = ~mclk;

    clock_hms_bcd dut (
        .mclk(mclk), .reset(reset), .tick_1s(tick_1s), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
        .inc_min(inc_min), .inc_hour(inc_hour),
        .hh(hh), .mm(mm), .ss(ss),
        .min_rco(min_rco), .hour_rco(hour_rco), .day_rco(day_rco), .ld_err(ld_err)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; registered results are compared one edge later.
    task automatic step(input logic t, input logic ld, input logic [7:0] lh, input logic [7:0] lm,
                        input logic [7:0] ls, input logic im, input logic ih, input logic r);
        logic [2:0]  exp_rco;
        logic [24:0] e;
        int          dh, dm, ds;
        bit          cm, ch;
        reset = r; tick_1s = t; load = ld; ld_hh = lh; ld_mm = lm; ld_ss = ls;
        inc_min = im; inc_hour = ih;
        #1;
        exp_rco[2] = t && m_s == 59;
        exp_rco[1] = exp_rco[2] && m_m == 59;
        exp_rco[0] = exp_rco[1] && m_h == 23;
        chk("rco", {21'b0, min_rco, hour_rco, day_rco}, {21'b0, exp_rco});
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (ld) begin
                dh = int'(lh[7:4]) * 10 + int'(lh[3:0]);
                dm = int'(lm[7:4]) * 10 + int'(lm[3:0]);
                ds = int'(ls[7:4]) * 10 + int'(ls[3:0]);
                if (lh[3:0] <= 9 && lm[3:0] <= 9 && ls[3:0] <= 9 &&
                    lm[7:4] <= 5 && ls[7:4] <= 5 && dh <= 23) begin
                    m_h = dh; m_m = dm; m_s = ds;
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                cm = t && m_s == 59;
                ch = cm && m_m == 59 && !im;
                if (t) m_s = (m_s + 1) % 60;
                if (im || cm) m_m = (m_m + 1) % 60;
                if (ih || ch) m_h = (m_h + 1) % 24;
            end
        end
        sb.push_back({to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), m_err});
        @(posedge mclk);
        #1;
        reset = 1'b0; tick_1s = 1'b0; load = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 24'd1, 24'd0);
        end else begin
            e = sb.pop_front();
            chk("time", {hh, mm, ss}, e[24:1]);
            chk("ld_err", {23'b0, ld_err}, {23'b0, e[0]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    endtask

    task automatic do_load(input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
        step(0, 1, lh, lm, ls, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0; tick_1s = 1'b0; load = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        ld_hh = 8'h00; ld_mm = 8'h00; ld_ss = 8'h00;
        @(posedge mclk);
        #1;

        // Reset, then three spaced ticks
        step(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        chk("reset_time", {hh, mm, ss}, 24'h000000);
        chk("reset_err", {23'b0, ld_err}, 24'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
            idle(4);
        end
        chk("three_ticks", {hh, mm, ss}, 24'h000003);

        // Day rollover
        do_load(8'h23, 8'h59, 8'h58);
        chk("load_235958", {hh, mm, ss}, 24'h235958);
        step(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        chk("tick_235959", {hh, mm, ss}, 24'h235959);
        tick_1s = 1'b1;
        #1;
        chk("day_rco_all", {21'b0, min_rco, hour_rco, day_rco}, 24'h7);
        step(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        chk("day_wrap", {hh, mm, ss}, 24'h000000);

        // Rejected loads: one-cycle ld_err each, time untouched
        do_load(8'h24, 8'h00, 8'h00);
        chk("bad_hh_err", {23'b0, ld_err}, 24'h1);
        idle(1);
        chk("bad_hh_clear", {23'b0, ld_err}, 24'h0);
        do_load(8'h00, 8'h00, 8'h5A);
        idle(1);
        do_load(8'h00, 8'h60, 8'h00);
        chk("bad_mm_err", {23'b0, ld_err}, 24'h1);
        idle(1);
        do_load(8'h19, 8'h00, 8'h00);
        chk("hh19_valid", {hh, mm, ss}, 24'h190000);
        chk("bad_loads_time", {hh, mm, ss}, 24'h190000);

        // inc_min with a tick at :59:59 wraps minutes once, hour held
        do_load(8'h10, 8'h59, 8'h59);
        step(1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        chk("inc_min_tick", {hh, mm, ss}, 24'h100000);

        // inc_hour wrap, then both set pulses together
        do_load(8'h23, 8'h10, 8'h00);
        step(0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        chk("inc_hour_wrap", {hh, mm, ss}, 24'h001000);
        step(0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0);
        chk("inc_both", {hh, mm, ss}, 24'h011100);

        // inc_hour coinciding with a tick hour carry advances hh once
        do_load(8'h22, 8'h59, 8'h59);
        step(1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        chk("inc_hour_carry", {hh, mm, ss}, 24'h230000);

        // Units-to-tens rollover inside the hour
        do_load(8'h09, 8'h59, 8'h59);
        step(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        chk("hour_units_roll", {hh, mm, ss}, 24'h100000);

        // Reset beats load and tick; load ignores tick
        do_load(8'h05, 8'h06, 8'h07);
        step(1, 1, 8'h12, 8'h34, 8'h56, 0, 0, 1);
        chk("reset_wins", {hh, mm, ss}, 24'h000000);
        step(1, 1, 8'h12, 8'h34, 8'h56, 0, 0, 0);
        chk("load_ignores_tick", {hh, mm, ss}, 24'h123456);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_hms_bcd.md
Name: clock_hms_bcd

Overview:
- Time-of-day counter for the clock datapath. Sits directly downstream of the 1 s enable generator; its `tick_1s` input is that generator's one-cycle RCO pulse.
- Keeps hours:minutes:seconds (24 h) as BCD digits, which drive the display stage.
- Supports a validated parallel time load and single-step minute/hour adjustment for setting the clock.
- Emits combinational carry strobes for cascading, such as a date or alarm stage.

Parameters:
- INIT_HH, 8'h00: BCD hour loaded on reset. Must be 00..23.
- INIT_MM, 8'h00: BCD minute loaded on reset. Must be 00..59.
- INIT_SS, 8'h00: BCD second loaded on reset. Must be 00..59.

Ports:
- mclk  in  1  system clock; all state updates on its posedge.
- reset  in  1  synchronous, active-high reset.
- tick_1s  in  1  one-cycle enable pulse, once per second.
- load  in  1  one-cycle request to load ld_hh/ld_mm/ld_ss.
- ld_hh  in  8  BCD hours to load: [7:4] tens, [3:0] units.
- ld_mm  in  8  BCD minutes to load.
- ld_ss  in  8  BCD seconds to load.
- inc_min  in  1  one-cycle pulse: add one minute, no carry into hours.
- inc_hour  in  1  one-cycle pulse: add one hour, no day carry.
- hh  out  8  BCD hours, registered.
- mm  out  8  BCD minutes, registered.
- ss  out  8  BCD seconds, registered.
- min_rco  out  1  combinational: tick_1s & ss==59.
- hour_rco  out  1  combinational: min_rco & mm==59.
- day_rco  out  1  combinational: hour_rco & hh==23.
- ld_err  out  1  registered: high for exactly one cycle after a rejected load.

Behaviour:
- **Reset.** On posedge mclk with reset=1: hh/mm/ss <= INIT_HH/INIT_MM/INIT_SS, ld_err <= 0. Reset overrides every other input in the same cycle. Reset mid-count or mid-load discards that operation.
- **Digit encoding.** Each digit is stored separately. Units digits are 0..9. Tens digits are 0..5 for minutes and seconds, and 0..2 for hours. Ranges are never exceeded. Non-BCD codes never appear on the outputs.
- **Priority per cycle (when reset=0):** load > (inc_min / inc_hour) > tick_1s.
- **Load.**
  - Valid when every units digit ≤ 9, mm and ss tens ≤ 5, and hh ≤ 23 (tens 2 requires units ≤ 3).
  - Valid load: hh/mm/ss take the loaded values next cycle and ld_err <= 0.
  - Invalid load: all registers are unchanged and ld_err <= 1 for one cycle.
  - A cycle with load=1 ignores tick_1s, inc_min and inc_hour entirely.
  - The carry outputs still reflect tick_1s combinationally in that cycle. The consumer must treat a load cycle as a resynchronisation point.
- **tick_1s (no load, no inc).**
  - ss increments; 59 -> 00 with minute carry.
  - mm increments on that carry; 59 -> 00 with hour carry.
  - hh increments on that carry; 23 -> 00.
  - Units rollover 9 -> 0 increments the tens digit in the same cycle.
  - Latency from tick to updated outputs: 1 clock.
- **inc_min.** mm += 1 with wrap 59 -> 00; hh is unaffected. If tick_1s is also high, seconds still advance normally. Any minute carry from ss 59 -> 00 is absorbed, so mm advances by exactly 1 that cycle.
- **inc_hour.** hh += 1 with wrap 23 -> 00. If it coincides with a tick-generated hour carry, hh advances by exactly 1.
- **Both inc pulses in one cycle.** Both apply independently: mm +1 and hh +1, with no cross-carry.
- **ld_err.** Deasserts the cycle after it asserts unless another invalid load occurs.
- **Carry outputs.** Pure functions of tick_1s and the current registers. They are unaffected by inc_* pulses.

Test Plan:
1. Reset with INIT defaults, then 3 tick_1s pulses spaced 5 cycles apart -> hh:mm:ss = 00:00:03; ld_err=0 throughout; no rco asserted.
2. Load 23:59:58 (valid), then 2 ticks -> after the first tick 23:59:59. The second tick cycle shows min_rco=hour_rco=day_rco=1 combinationally; the next cycle shows 00:00:00.
3. Load hh=8'h24, then load ss=8'h5A, then load mm=8'h60 -> each is rejected. Time stays unchanged, and ld_err is high for exactly one cycle after each load.
4. At 10:59:59, assert inc_min together with tick_1s -> next cycle shows 10:00:00 (minute advances once and wraps, hour not incremented).
5. At 23:10:00, pulse inc_hour -> 00:10:00 and day_rco=0. Then pulse inc_min and inc_hour together -> 01:11:00.
6. Assert reset concurrently with load=1 (ld=12:34:56) and tick_1s -> outputs = INIT values and ld_err=0. Load 12:34:56 with tick_1s in the same cycle -> 12:34:56 (tick ignored).
